// File: rtl/background_model_ctrl.sv
// background_model_ctrl: frame sequencer feeding background_model_compute from a pixel stream and BRAM.
// Optional BG_CTRL_FRAME_CHECK_EN adds a sticky frame_err output that checks s_last against the pixel count.
module background_model_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 19,
  parameter int MEM_RD_LAT = 1,
  parameter int PIPE_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        cfg_alpha,
  input  logic [3:0]        cfg_init_frames,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic              bg_rd_en,
  output logic [ADDR_W-1:0] bg_rd_addr,
  input  logic [7:0]        bg_rd_data,
  output logic              bg_wr_en,
  output logic [ADDR_W-1:0] bg_wr_addr,
  output logic [7:0]        bg_wr_data,
  output logic              cmp_ce,
  output logic [7:0]        cmp_image,
  output logic [7:0]        cmp_background,
  output logic [7:0]        cmp_alpha,
  output logic [7:0]        cmp_one_minus_alpha,
  input  logic [7:0]        cmp_result,
  output logic              busy,
  output logic              done,
  output logic [3:0]        frame_cnt
`ifdef BG_CTRL_FRAME_CHECK_EN
  ,
  output logic              frame_err
`endif
);
  localparam int D = MEM_RD_LAT + PIPE_LAT;
  localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [ADDR_W:0] LASTPIX = NPIX - 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W:0]   acc_q;
  logic [3:0]        fcnt_q;
  logic [7:0]        a_q, oma_q, img_h_q, bg_h_q, a_sat;
  logic [D-1:0]      vld_q;
  logic [ADDR_W-1:0] addr_q [D];
  logic [7:0]        pix_q [MEM_RD_LAT];
  logic              go, accept, last_acc, learn;
  assign go       = state_q == IDLE && start;
  assign s_ready  = !rst && state_q == RUN && acc_q < NPIX;
  assign accept   = s_valid && s_ready;
  assign last_acc = acc_q == LASTPIX;
  assign learn    = fcnt_q < cfg_init_frames;
  assign a_sat    = cfg_alpha > 8'd128 ? 8'd128 : cfg_alpha;
  assign done     = state_q == DRAIN && vld_q == '0;
  assign busy     = state_q != IDLE;
  assign frame_cnt  = fcnt_q;
  assign bg_rd_en   = accept;
  assign bg_rd_addr = acc_q[ADDR_W-1:0];
  // Writes are masked while rst is high so a mid-frame reset cannot corrupt memory.
  assign bg_wr_en   = vld_q[D-1] && !rst;
  assign bg_wr_addr = addr_q[D-1];
  assign bg_wr_data = cmp_result;
  assign cmp_ce         = vld_q[MEM_RD_LAT-1];
  assign cmp_image      = cmp_ce ? pix_q[MEM_RD_LAT-1] : img_h_q;
  assign cmp_background = cmp_ce ? bg_rd_data : bg_h_q;
  assign cmp_alpha           = a_q;
  assign cmp_one_minus_alpha = oma_q;
  always_comb begin
    state_d = go ? RUN : (accept && last_acc) ? DRAIN : done ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      fcnt_q  <= '0;
      a_q     <= '0;
      oma_q   <= '0;
      img_h_q <= '0;
      bg_h_q  <= '0;
      vld_q   <= '0;
      for (int i = 0; i < D; i++) addr_q[i] <= '0;
      for (int i = 0; i < MEM_RD_LAT; i++) pix_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        acc_q <= '0;
        a_q   <= learn ? 8'd0 : a_sat;
        oma_q <= learn ? 8'd128 : 8'd128 - a_sat;
      end else if (accept) begin
        acc_q <= acc_q + 1'b1;
      end
      if (done && fcnt_q != 4'd15) fcnt_q <= fcnt_q + 1'b1;
      if (cmp_ce) begin
        img_h_q <= cmp_image;
        bg_h_q  <= cmp_background;
      end
      vld_q     <= {vld_q[D-2:0], accept};
      addr_q[0] <= acc_q[ADDR_W-1:0];
      for (int i = 1; i < D; i++) addr_q[i] <= addr_q[i-1];
      pix_q[0] <= s_data;
      for (int i = 1; i < MEM_RD_LAT; i++) pix_q[i] <= pix_q[i-1];
    end
  end
`ifdef BG_CTRL_FRAME_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst || go) err_q <= 1'b0;
    else if (accept && (s_last != last_acc)) err_q <= 1'b1;
  end
  assign frame_err = err_q;
`else
  logic unused_last;
  assign unused_last = s_last;
`endif
endmodule

// File: tb/tb_background_model_ctrl.sv
// tb_background_model_ctrl: directed bench for background_model_ctrl on a 4x2 frame.
// Includes a behavioural BRAM and a blend pipeline standing in for the compute block.
module tb_background_model_ctrl;
  localparam int W = 4, H = 2, AW = 3, L = 1, P = 4, N = W * H;
  logic clk = 0, rst = 1, start = 0, s_valid = 0, s_last = 0;
  logic [7:0] cfg_alpha = 0, s_data = 0;
  logic [3:0] cfg_init_frames = 0;
  logic s_ready, bg_rd_en, bg_wr_en, cmp_ce, busy, done;
  logic [AW-1:0] bg_rd_addr, bg_wr_addr;
  logic [7:0] bg_rd_data, bg_wr_data, cmp_image, cmp_background, cmp_alpha, cmp_one_minus_alpha, cmp_result;
  logic [3:0] frame_cnt;
`ifdef BG_CTRL_FRAME_CHECK_EN
  logic frame_err;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  background_model_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .MEM_RD_LAT(L), .PIPE_LAT(P)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_alpha(cfg_alpha), .cfg_init_frames(cfg_init_frames),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .bg_rd_en(bg_rd_en), .bg_rd_addr(bg_rd_addr), .bg_rd_data(bg_rd_data),
    .bg_wr_en(bg_wr_en), .bg_wr_addr(bg_wr_addr), .bg_wr_data(bg_wr_data),
    .cmp_ce(cmp_ce), .cmp_image(cmp_image), .cmp_background(cmp_background),
    .cmp_alpha(cmp_alpha), .cmp_one_minus_alpha(cmp_one_minus_alpha), .cmp_result(cmp_result),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
`ifdef BG_CTRL_FRAME_CHECK_EN
    , .frame_err(frame_err)
`endif
  );

  // Memory with one-cycle read latency; fill preloads every word.
  logic [7:0] mem [N];
  logic fill = 0;
  logic [7:0] fill_val = 0;
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < N; i++) mem[i] <= fill_val;
    else if (bg_wr_en) mem[bg_wr_addr] <= bg_wr_data;
    if (bg_rd_en) bg_rd_data <= mem[bg_rd_addr];
  end

  // Compute block: out = (alpha*bg + (1-alpha)*img) >> 7 after P cycles.
  logic [15:0] blend;
  logic [7:0] pipe [P];
  assign blend = 16'(cmp_alpha) * 16'(cmp_background) + 16'(cmp_one_minus_alpha) * 16'(cmp_image);
  always @(posedge clk) begin
    pipe[0] <= blend[14:7];
    for (int k = 1; k < P; k++) pipe[k] <= pipe[k-1];
  end
  assign cmp_result = pipe[P-1];

  int cyc = 0, acc_n = 0, wr_n = 0, rd_n = 0, done_n = 0;
  int acc_cyc [128], wr_cyc [128];
  logic [AW-1:0] acc_addr [128], wr_addr_l [128];
  logic [7:0] wr_data_l [128];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (s_valid && s_ready) begin
      acc_cyc[acc_n & 127] <= cyc;
      acc_addr[acc_n & 127] <= bg_rd_addr;
      acc_n <= acc_n + 1;
    end
    if (bg_wr_en) begin
      wr_cyc[wr_n & 127] <= cyc;
      wr_addr_l[wr_n & 127] <= bg_wr_addr;
      wr_data_l[wr_n & 127] <= bg_wr_data;
      wr_n <= wr_n + 1;
    end
    if (bg_rd_en) rd_n <= rd_n + 1;
    if (done) done_n <= done_n + 1;
  end

  int gap [N] = '{0, 2, 1, 0, 3, 0, 1, 2};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [7:0] v);
    fill_val = v; fill = 1; tick(); fill = 0;
  endtask

  task automatic start_frame(input logic [7:0] alpha, input logic [3:0] init);
    cfg_alpha = alpha; cfg_init_frames = init; start = 1; tick(); start = 0;
  endtask

  task automatic feed(input logic [7:0] img, input bit gaps, input int last_idx);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat (gap[i]) begin s_valid = 0; s_last = 0; start = 1; tick(); start = 0; end
      s_valid = 1; s_data = img; s_last = (i == last_idx);
      for (int b = 0; b < 20 && !s_ready; b++) tick();
      if (!s_ready) begin
        tests++; fails++;
        $display("FAIL handshake pixel %0d: s_ready stayed 0, required 1", i);
      end
      tick();
    end
    s_valid = 0; s_last = 0;
  endtask

  task automatic wait_done(input int d0);
    for (int b = 0; b < 40 && done_n == d0; b++) tick();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1; repeat (3) tick(); rst = 0; tick();
    tests++;
    if ({s_ready, bg_rd_en, bg_wr_en, cmp_ce, busy, done} !== 6'b0 || frame_cnt !== 4'd0 ||
        cmp_alpha !== 8'd0 || bg_wr_addr !== '0) begin
      fails++;
      $display("FAIL reset: ctl=%b frame_cnt=%0d alpha=%0d wr_addr=%0d, required all 0",
               {s_ready, bg_rd_en, bg_wr_en, cmp_ce, busy, done}, frame_cnt, cmp_alpha, bg_wr_addr);
    end
  endtask

  task automatic test_learning();
    int w0, r0, d0;
    preload(8'd100);
    w0 = wr_n; r0 = rd_n; d0 = done_n;
    start_frame(8'd96, 4'd1);
    tests++;
    if (cmp_alpha !== 8'd0 || cmp_one_minus_alpha !== 8'd128 || busy !== 1'b1) begin
      fails++;
      $display("FAIL learn_alpha: a=%0d oma=%0d busy=%b, required 0/128/1", cmp_alpha, cmp_one_minus_alpha, busy);
    end
    feed(8'd77, 0, N - 1);
    wait_done(d0);
    for (int k = 0; k < N; k++) begin
      tests++;
      if (wr_addr_l[(w0 + k) & 127] !== AW'(k) || wr_data_l[(w0 + k) & 127] !== 8'd77) begin
        fails++;
        $display("FAIL learn_wr[%0d]: addr=%0d data=%0d, required addr=%0d data=77",
                 k, wr_addr_l[(w0 + k) & 127], wr_data_l[(w0 + k) & 127], k);
      end
    end
    tests++;
    if (wr_n - w0 != N || rd_n - r0 != N || done_n - d0 != 1 || frame_cnt !== 4'd1) begin
      fails++;
      $display("FAIL learn_counts: wr=%0d rd=%0d done=%0d frame_cnt=%0d, required 8/8/1/1",
               wr_n - w0, rd_n - r0, done_n - d0, frame_cnt);
    end
  endtask

  task automatic test_normal();
    int w0, a0, d0;
    preload(8'd100);
    w0 = wr_n; a0 = acc_n; d0 = done_n;
    start_frame(8'd96, 4'd1);
    tests++;
    if (cmp_alpha !== 8'd96 || cmp_one_minus_alpha !== 8'd32) begin
      fails++;
      $display("FAIL normal_alpha: a=%0d oma=%0d, required 96/32", cmp_alpha, cmp_one_minus_alpha);
    end
    feed(8'd200, 0, N - 1);
    wait_done(d0);
    for (int k = 0; k < N; k++) begin
      tests++;
      if (wr_addr_l[(w0 + k) & 127] !== AW'(k) || wr_data_l[(w0 + k) & 127] !== 8'd125 ||
          wr_cyc[(w0 + k) & 127] - acc_cyc[(a0 + k) & 127] != 5) begin
        fails++;
        $display("FAIL normal_wr[%0d]: addr=%0d data=%0d lat=%0d, required addr=%0d data=125 lat=5",
                 k, wr_addr_l[(w0 + k) & 127], wr_data_l[(w0 + k) & 127],
                 wr_cyc[(w0 + k) & 127] - acc_cyc[(a0 + k) & 127], k);
      end
    end
    tests++;
    if (wr_n - w0 != N || frame_cnt !== 4'd2) begin
      fails++;
      $display("FAIL normal_counts: wr=%0d frame_cnt=%0d, required 8/2", wr_n - w0, frame_cnt);
    end
  endtask

  task automatic test_saturation();
    int w0, d0;
    preload(8'd100);
    w0 = wr_n; d0 = done_n;
    start_frame(8'd200, 4'd1);
    tests++;
    if (cmp_alpha !== 8'd128 || cmp_one_minus_alpha !== 8'd0) begin
      fails++;
      $display("FAIL sat_alpha: a=%0d oma=%0d, required 128/0", cmp_alpha, cmp_one_minus_alpha);
    end
    feed(8'd200, 0, N - 1);
    wait_done(d0);
    for (int k = 0; k < N; k++) begin
      tests++;
      if (wr_data_l[(w0 + k) & 127] !== 8'd100) begin
        fails++;
        $display("FAIL sat_wr[%0d]: data=%0d, required 100", k, wr_data_l[(w0 + k) & 127]);
      end
    end
  endtask

  task automatic test_gaps();
    int w0, r0, d0;
    preload(8'd100);
    w0 = wr_n; r0 = rd_n; d0 = done_n;
    start_frame(8'd96, 4'd1);
    cfg_alpha = 8'd10;
    cfg_init_frames = 4'd15;
    feed(8'd200, 1, N - 1);
    wait_done(d0);
    for (int k = 0; k < N; k++) begin
      tests++;
      if (wr_addr_l[(w0 + k) & 127] !== AW'(k) || wr_data_l[(w0 + k) & 127] !== 8'd125) begin
        fails++;
        $display("FAIL gaps_wr[%0d]: addr=%0d data=%0d, required addr=%0d data=125",
                 k, wr_addr_l[(w0 + k) & 127], wr_data_l[(w0 + k) & 127], k);
      end
    end
    tests++;
    if (wr_n - w0 != N || rd_n - r0 != N || done_n - d0 != 1 || frame_cnt !== 4'd4 ||
        busy !== 1'b0 || cmp_alpha !== 8'd96) begin
      fails++;
      $display("FAIL gaps_counts: wr=%0d rd=%0d done=%0d frame_cnt=%0d busy=%b a=%0d, required 8/8/1/4/0/96",
               wr_n - w0, rd_n - r0, done_n - d0, frame_cnt, busy, cmp_alpha);
    end
  endtask

  task automatic test_reset_mid();
    int w0, a0;
    preload(8'd100);
    start_frame(8'd96, 4'd1);
    s_valid = 1; s_data = 8'd200;
    repeat (3) tick();
    s_data = 8'd201;
    tick();
    rst = 1;
    w0 = wr_n;
    tick(); tick();
    rst = 0; s_valid = 0;
    repeat (8) tick();
    tests++;
    if (wr_n != w0) begin
      fails++;
      $display("FAIL midrst_wr: %0d writes after reset, required 0", wr_n - w0);
    end
    tests++;
    if ({s_ready, bg_rd_en, bg_wr_en, cmp_ce, busy, done} !== 6'b0 || frame_cnt !== 4'd0 ||
        cmp_alpha !== 8'd0 || cmp_one_minus_alpha !== 8'd0 || bg_rd_addr !== '0 || bg_wr_addr !== '0) begin
      fails++;
      $display("FAIL midrst_state: ctl=%b frame_cnt=%0d a=%0d oma=%0d rd_addr=%0d wr_addr=%0d, required all 0",
               {s_ready, bg_rd_en, bg_wr_en, cmp_ce, busy, done}, frame_cnt, cmp_alpha,
               cmp_one_minus_alpha, bg_rd_addr, bg_wr_addr);
    end
    w0 = wr_n; a0 = acc_n;
    preload(8'd100);
    start_frame(8'd96, 4'd1);
    feed(8'd55, 0, N - 1);
    wait_done(done_n);
    tests++;
    if (acc_addr[a0 & 127] !== '0 || wr_n - w0 != N || wr_addr_l[w0 & 127] !== '0 ||
        wr_data_l[(w0 + N - 1) & 127] !== 8'd55 || frame_cnt !== 4'd1) begin
      fails++;
      $display("FAIL midrst_restart: first_rd=%0d wr=%0d first_wr=%0d last_data=%0d frame_cnt=%0d, required 0/8/0/55/1",
               acc_addr[a0 & 127], wr_n - w0, wr_addr_l[w0 & 127], wr_data_l[(w0 + N - 1) & 127], frame_cnt);
    end
  endtask

`ifdef BG_CTRL_FRAME_CHECK_EN
  task automatic test_frame_check();
    start_frame(8'd96, 4'd0);
    feed(8'd10, 0, 5);
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL fcheck_set: frame_err=%b, required 1", frame_err);
    end
    wait_done(done_n);
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL fcheck_sticky: frame_err=%b, required 1", frame_err);
    end
    start_frame(8'd96, 4'd0);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL fcheck_clear: frame_err=%b, required 0", frame_err);
    end
    feed(8'd10, 0, N - 1);
    wait_done(done_n);
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL fcheck_good: frame_err=%b, required 0", frame_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_learning();
    test_normal();
    test_saturation();
    test_gaps();
    test_reset_mid();
`ifdef BG_CTRL_FRAME_CHECK_EN
    test_frame_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/background_model_ctrl.md
Name: background_model_ctrl

Overview:
Frame-level sequencer for the background_model_compute datapath. It accepts a pixel stream with a valid/ready handshake and fetches the matching stored background pixel from a single-clock BRAM. It drives the compute block with alpha/one_minus_alpha and ce, then writes the updated background back to BRAM at the delayed address. It sits between the video input and the background memory, and forces the first cfg_init_frames frames to a straight copy of the image (learning phase).

Parameters:
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
ADDR_W, 19, BRAM address width (must hold IMG_WIDTH*IMG_HEIGHT-1)
MEM_RD_LAT, 1, BRAM read latency in cycles
PIPE_LAT, 4, compute block latency (ce/in_background to out_background)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin one frame (ignored unless IDLE)
cfg_alpha  in  8  Q1.7 background weight, latched at start
cfg_init_frames  in  4  number of learning frames, latched at start
s_data  in  8  image pixel
s_valid  in  1  pixel valid
s_ready  out  1  pixel accepted when s_valid&&s_ready
s_last  in  1  marks last pixel of frame (checked only with the optional feature)
bg_rd_en  out  1  BRAM read enable
bg_rd_addr  out  ADDR_W  BRAM read address
bg_rd_data  in  8  BRAM read data, MEM_RD_LAT after bg_rd_en
bg_wr_en  out  1  BRAM write enable
bg_wr_addr  out  ADDR_W  BRAM write address
bg_wr_data  out  8  updated background (= cmp_result)
cmp_ce  out  1  compute ce
cmp_image  out  8  compute in_image
cmp_background  out  8  compute in_background
cmp_alpha  out  8  compute alpha
cmp_one_minus_alpha  out  8  compute one_minus_alpha
cmp_result  in  8  compute out_background
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the last write of a frame has issued
frame_cnt  out  4  completed frames, saturates at 15

Behaviour:
- Reset: state IDLE; s_ready, bg_rd_en, bg_wr_en, cmp_ce, busy, done = 0; frame_cnt, pixel counter, all address/data regs = 0; valid shift register cleared. No BRAM write may occur after reset is applied, even mid-frame.
- FSM: IDLE -> RUN on start. RUN -> DRAIN after the W*H-th accepted pixel. DRAIN -> IDLE when the valid pipe is empty; done pulses in that same cycle.
- At start: if frame_cnt < cfg_init_frames, the frame is a learning frame: a=0, oma=128. Otherwise a=min(cfg_alpha,128), oma=128-a. a/oma are held constant for the whole frame.
- s_ready = (state==RUN) && (accepted < W*H). Accept at cycle T: bg_rd_en=1, bg_rd_addr=pixel counter; the image is delayed MEM_RD_LAT cycles.
- Cycle T+MEM_RD_LAT: cmp_ce=1, cmp_image=delayed pixel, cmp_background=bg_rd_data. In cycles with no slot, cmp_ce=0 and the other cmp inputs hold.
- Cycle T+MEM_RD_LAT+PIPE_LAT: bg_wr_en=1, bg_wr_addr=address of the pixel accepted at T, bg_wr_data=cmp_result. Implement with a valid+address shift register of depth MEM_RD_LAT+PIPE_LAT.
- Back-to-back accepts give one write per cycle. Gaps in s_valid propagate as gaps in writes.
- Pixel counter runs 0..W*H-1 and resets to 0 at each start.
- No read-after-write hazard: a new frame cannot start until DRAIN completes.
- start pulses while busy are ignored.
- frame_cnt increments at done and saturates at 15.
- cfg_* changes during a frame take no effect until the next start.

Optional Feature:
BG_CTRL_FRAME_CHECK_EN: adds output frame_err (1 bit, sticky, cleared by rst or by start). frame_err is set when s_last is accepted at a pixel index != W*H-1, or when the W*H-th pixel is accepted without s_last. Frame length is still governed by the counter. Without the macro, s_last is ignored and frame_err does not exist.

Test Plan:
- Learning frame: cfg_init_frames=1, frame_cnt=0, image all 77, BRAM all 100 -> every bg_wr_data=77; cmp_alpha=0, cmp_one_minus_alpha=128.
- Normal update: cfg_alpha=96 (oma=32), image 200, BRAM 100 -> 50+75, bg_wr_data=125 at all W*H addresses, each write exactly 5 cycles after its accept.
- Alpha saturation: cfg_alpha=200 -> cmp_alpha=128, oma=0, BRAM 100 is written back as 100.
- Handshake gaps: random s_valid on a 4x2 frame -> exactly 8 reads and 8 writes, addresses 0..7 in order; done pulses once; frame_cnt increments by 1; start during busy is ignored.
- Reset mid-frame: assert rst 2 cycles after the 3rd accept -> no bg_wr_en for that pixel or after; all outputs 0; a fresh start restarts at address 0.
- Frame check (macro on): s_last on pixel 5 of an 8-pixel frame -> frame_err=1, which stays set until the next start.
